// File: rtl/trace_pkg.sv
// Shared constants and state type for the trace-buffer dump controller.
package trace_pkg;

    localparam int TRACE_EN_BIT    = 0;
    localparam int TRACE_FLUSH_BIT = 1;

    localparam logic [7:0] TRACE_PRE0  = 8'h5A;
    localparam logic [7:0] TRACE_PRE1  = 8'hC3;
    localparam logic [6:0] TRACE_HDR   = 7'b1010000;
    localparam logic [7:0] TRACE_TRAIL = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_READ,
        ST_SEND,
        ST_TRAILER,
        ST_FLUSH,
        ST_DONE
    } trace_dump_state_e;

endpackage

// File: rtl/mem_split32.sv
// Split request/readout memory port shared with the tile's trace buffer.
interface MemSplit32;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport Master (output req, output we, output addr, output wdata, input rdata);
    modport Slave  (input req, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/trace_byte_ser.sv
// Shifts a loaded frame (1-9 bytes, LSB first) onto a valid/ready byte stream.
module trace_byte_ser (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [71:0] frame_i,
    input  logic [3:0]  nbytes_i,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic        ser_done_o
);

    logic [71:0] sh_q, sh_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        vld_q, vld_d;

    // A load in the same cycle as the last transfer chains frames without a bubble.
    always_comb begin
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        vld_d      = vld_q;
        ser_done_o = 1'b0;
        if (vld_q && tx_ready_i) begin
            if (cnt_q == 4'd1) begin
                vld_d      = 1'b0;
                sh_d       = '0;
                ser_done_o = 1'b1;
            end else begin
                sh_d  = {8'h00, sh_q[71:8]};
                cnt_d = cnt_q - 4'd1;
            end
        end
        if (load_i) begin
            sh_d  = frame_i;
            cnt_d = nbytes_i;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

    assign tx_data_o  = sh_q[7:0];
    assign tx_valid_o = vld_q;

endmodule

// File: rtl/trace_dump_ctrl.sv
// Dumps the trace buffer as a framed byte stream, then flushes it.
// Optional TRACE_DUMP_SKIP_EMPTY_EN: drop all-zero entries and append a sent-frame count.
module trace_dump_ctrl
    import trace_pkg::*;
#(
    parameter int CAPACITY   = 256,
    parameter int RD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trace_en_i,
    input  logic       dump_req_i,
    output logic [3:0] trace_ctrl_o,
    input  logic       trace_flush_end_i,
    MemSplit32.Master  trace_if,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       done_o
);

    localparam int               IDX_W     = $clog2(CAPACITY);
    localparam logic [2:0]       CAP_FIRST = 3'(RD_LATENCY);
    localparam logic [2:0]       RD_LAST   = 3'(RD_LATENCY + 2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CAPACITY - 1);

    trace_dump_state_e state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [2:0]        rd_cnt_q, rd_cnt_d;
    logic [31:0]       addr_word_q, addr_word_d;
    logic [31:0]       data_word_q, data_word_d;

    logic              ser_load, ser_done;
    logic [71:0]       ser_frame;
    logic [3:0]        ser_nbytes;
    logic [2:0]        cap_sel;
    logic [71:0]       entry_frame, trail_frame;
    logic [3:0]        trail_nbytes;
    logic              skip_entry;

    // The we flag is the last word read, so it is taken straight from rdata.
    assign cap_sel     = rd_cnt_q - CAP_FIRST;
    assign entry_frame = {data_word_q, addr_word_q, TRACE_HDR, trace_if.rdata[0]};

`ifdef TRACE_DUMP_SKIP_EMPTY_EN
    logic [15:0] sent_cnt_q, sent_cnt_d;

    assign skip_entry   = (addr_word_q == 32'h0) && (data_word_q == 32'h0) && !trace_if.rdata[0];
    assign trail_frame  = {48'h0, sent_cnt_q, TRACE_TRAIL};
    assign trail_nbytes = 4'd3;
`else
    assign skip_entry   = 1'b0;
    assign trail_frame  = {64'h0, TRACE_TRAIL};
    assign trail_nbytes = 4'd1;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rd_cnt_d    = rd_cnt_q;
        addr_word_d = addr_word_q;
        data_word_d = data_word_q;
        ser_load    = 1'b0;
        ser_frame   = '0;
        ser_nbytes  = '0;
`ifdef TRACE_DUMP_SKIP_EMPTY_EN
        sent_cnt_d  = sent_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: if (dump_req_i) begin
                state_d    = ST_PREAMBLE;
                idx_d      = '0;
                ser_load   = 1'b1;
                ser_frame  = {56'h0, TRACE_PRE1, TRACE_PRE0};
                ser_nbytes = 4'd2;
`ifdef TRACE_DUMP_SKIP_EMPTY_EN
                sent_cnt_d = '0;
`endif
            end
            ST_PREAMBLE: if (ser_done) begin
                state_d  = ST_READ;
                rd_cnt_d = '0;
            end
            ST_READ: begin
                rd_cnt_d = rd_cnt_q + 3'd1;
                if (rd_cnt_q >= CAP_FIRST) begin
                    if (cap_sel == 3'd0) addr_word_d = trace_if.rdata;
                    if (cap_sel == 3'd1) data_word_d = trace_if.rdata;
                end
                if (rd_cnt_q == RD_LAST) begin
                    if (!skip_entry) begin
                        state_d    = ST_SEND;
                        ser_load   = 1'b1;
                        ser_frame  = entry_frame;
                        ser_nbytes = 4'd9;
`ifdef TRACE_DUMP_SKIP_EMPTY_EN
                        if (sent_cnt_q != 16'hFFFF) sent_cnt_d = sent_cnt_q + 16'd1;
`endif
                    end else if (idx_q == IDX_LAST) begin
                        state_d    = ST_TRAILER;
                        ser_load   = 1'b1;
                        ser_frame  = trail_frame;
                        ser_nbytes = trail_nbytes;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        rd_cnt_d = '0;
                    end
                end
            end
            ST_SEND: if (ser_done) begin
                if (idx_q == IDX_LAST) begin
                    state_d    = ST_TRAILER;
                    ser_load   = 1'b1;
                    ser_frame  = trail_frame;
                    ser_nbytes = trail_nbytes;
                end else begin
                    state_d  = ST_READ;
                    idx_d    = idx_q + 1'b1;
                    rd_cnt_d = '0;
                end
            end
            ST_TRAILER: if (ser_done) state_d = ST_FLUSH;
            ST_FLUSH:   if (trace_flush_end_i) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rd_cnt_q   <= '0;
`ifdef TRACE_DUMP_SKIP_EMPTY_EN
            sent_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_cnt_q   <= rd_cnt_d;
`ifdef TRACE_DUMP_SKIP_EMPTY_EN
            sent_cnt_q <= sent_cnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        addr_word_q <= addr_word_d;
        data_word_q <= data_word_d;
    end

    // Tracing is only enabled while idle; the readout port never writes.
    always_comb begin
        trace_ctrl_o   = 4'h0;
        trace_if.req   = 1'b0;
        trace_if.addr  = 32'h0;
        trace_if.we    = 1'b0;
        trace_if.wdata = 32'h0;
        busy_o         = (state_q != ST_IDLE);
        done_o         = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE:  trace_ctrl_o[TRACE_EN_BIT] = trace_en_i & ~rst;
            ST_READ:  if (rd_cnt_q < 3'd3) begin
                trace_if.req  = 1'b1;
                trace_if.addr = 32'({idx_q, rd_cnt_q[1:0]});
            end
            ST_FLUSH: trace_ctrl_o[TRACE_FLUSH_BIT] = 1'b1;
            default:  ;
        endcase
    end

    trace_byte_ser u_ser (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ser_load),
        .frame_i    (ser_frame),
        .nbytes_i   (ser_nbytes),
        .tx_ready_i (tx_ready_i),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .ser_done_o (ser_done)
    );

endmodule

// File: tb/tb_trace_dump_ctrl.sv
// Scoreboard bench for trace_dump_ctrl with a behavioural trace-buffer readout model.
module tb_trace_dump_ctrl;
    import trace_pkg::*;

    localparam int CAPACITY   = 4;
    localparam int RD_LATENCY = 1;
    localparam int NWORDS     = CAPACITY * 4;
    localparam int AW         = $clog2(NWORDS);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trace_en_i = 1'b0;
    logic       dump_req_i = 1'b0;
    logic       trace_flush_end_i = 1'b0;
    logic       tx_ready_i = 1'b1;
    logic [3:0] trace_ctrl_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o, busy_o, done_o;

    MemSplit32 mif();

    logic [31:0] mem [NWORDS];
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          stab_err = 0;
    int          if_err = 0;
    logic        hold_p = 1'b0;
    logic [7:0]  hold_data = 8'h00;

    always #5 clk = ~clk;

    trace_dump_ctrl #(.CAPACITY(CAPACITY), .RD_LATENCY(RD_LATENCY)) dut (
        .clk               (clk),
        .rst               (rst),
        .trace_en_i        (trace_en_i),
        .dump_req_i        (dump_req_i),
        .trace_ctrl_o      (trace_ctrl_o),
        .trace_flush_end_i (trace_flush_end_i),
        .trace_if          (mif),
        .tx_data_o         (tx_data_o),
        .tx_valid_o        (tx_valid_o),
        .tx_ready_i        (tx_ready_i),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    // Trace buffer readout with one cycle of latency.
    always @(posedge clk) if (mif.req) mif.rdata <= mem[mif.addr[AW-1:0]];

    always @(negedge clk) begin
        if (rst) begin
            hold_p = 1'b0;
        end else begin
            if (hold_p && (!tx_valid_o || tx_data_o !== hold_data)) stab_err++;
            if (tx_valid_o && tx_ready_i) rx_q.push_back(tx_data_o);
            hold_p    = tx_valid_o && !tx_ready_i;
            hold_data = tx_data_o;
            if (mif.we !== 1'b0 || mif.wdata !== 32'h0) if_err++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic load_basic();
        for (int i = 0; i < NWORDS; i++) mem[i] = 32'h0;
        mem[4] = 32'h0000_1004;
        mem[5] = 32'hDEAD_BEEF;
        mem[6] = 32'h1;
    endtask

    task automatic load_random();
        for (int e = 0; e < CAPACITY; e++) begin
            mem[4*e]   = $urandom();
            mem[4*e+1] = $urandom();
            mem[4*e+2] = {31'h0, 1'($urandom())};
            mem[4*e+3] = 32'h0;
        end
        mem[8] = 32'h0; mem[9] = 32'h0; mem[10] = 32'h0;
    endtask

    // Expected byte stream for one complete dump of the current memory image.
    function automatic void push_dump();
        logic [31:0] a, d;
        logic        w;
        logic [15:0] sent;
        sent = 16'h0;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        for (int e = 0; e < CAPACITY; e++) begin
            a = mem[4*e];
            d = mem[4*e+1];
            w = mem[4*e+2][0];
`ifdef TRACE_DUMP_SKIP_EMPTY_EN
            if (a == 32'h0 && d == 32'h0 && !w) continue;
`endif
            exp_q.push_back({7'b1010000, w});
            for (int b = 0; b < 4; b++) exp_q.push_back(a[8*b +: 8]);
            for (int b = 0; b < 4; b++) exp_q.push_back(d[8*b +: 8]);
            sent = sent + 16'h1;
        end
        exp_q.push_back(8'hEE);
`ifdef TRACE_DUMP_SKIP_EMPTY_EN
        exp_q.push_back(sent[7:0]);
        exp_q.push_back(sent[15:8]);
`endif
    endfunction

    // Pops both queues; returns the number of differing positions.
    function automatic int drain_compare(output int first_at, output logic [7:0] got,
                                         output logic [7:0] want);
        int         mm, pos;
        logic [7:0] g, e;
        mm = 0; pos = 0; first_at = -1; got = 8'h00; want = 8'h00;
        while (rx_q.size() > 0 || exp_q.size() > 0) begin
            g = 8'hxx;
            e = 8'hxx;
            if (rx_q.size() > 0) g = rx_q.pop_front();
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (g !== e) begin
                if (mm == 0) begin first_at = pos; got = g; want = e; end
                mm++;
            end
            pos++;
        end
        return mm;
    endfunction

    task automatic run_dump(input int flush_delay, input bit toggle, input int extra_req_cyc,
                            output int first_flush, output int flush_cycles,
                            output int done_cnt, output int ctrl_bad, output bit timed_out);
        int   cyc, post;
        bit   done_seen;
        logic [3:0] mask;
        mask = ~(4'b0001 << TRACE_FLUSH_BIT);
        first_flush = 0; flush_cycles = 0; done_cnt = 0; ctrl_bad = 0;
        timed_out = 1'b0; done_seen = 1'b0; post = 0; cyc = 0;
        @(posedge clk); #1 dump_req_i = 1'b1;
        @(posedge clk); #1 dump_req_i = 1'b0;
        while (1) begin
            cyc++;
            if (toggle) tx_ready_i = ~tx_ready_i;
            dump_req_i = (cyc == extra_req_cyc);
            @(negedge clk);
            if (trace_ctrl_o[TRACE_FLUSH_BIT]) begin
                if (first_flush == 0) first_flush = cyc;
                flush_cycles++;
                trace_flush_end_i = (flush_cycles == flush_delay + 1);
            end else begin
                trace_flush_end_i = 1'b0;
            end
            if (busy_o && (trace_ctrl_o & mask) != 4'h0) ctrl_bad++;
            if (done_o) begin done_cnt++; done_seen = 1'b1; end
            if (done_seen) post++;
            if (post == 6) break;
            if (cyc > 3000) begin timed_out = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        tx_ready_i = 1'b1; dump_req_i = 1'b0; trace_flush_end_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; trace_en_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({trace_ctrl_o, tx_valid_o, tx_data_o, busy_o, done_o, mif.req} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs ctrl=%h valid=%b data=%h busy=%b done=%b req=%b want all 0",
                     trace_ctrl_o, tx_valid_o, tx_data_o, busy_o, done_o, mif.req);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (trace_ctrl_o !== (4'b0001 << TRACE_EN_BIT)) begin
            errors++;
            $display("FAIL idle_enable got=%h want=%h", trace_ctrl_o, 4'b0001 << TRACE_EN_BIT);
        end
        @(posedge clk); #1 trace_en_i = 1'b0;
        @(negedge clk);
        checks++;
        if (trace_ctrl_o !== 4'h0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_disabled ctrl=%h busy=%b want 0/0", trace_ctrl_o, busy_o);
        end
    endtask

    task automatic test_basic();
        logic [7:0] lit [9] = '{8'hA1, 8'h04, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int ff, fc, dc, cb, mm, fa, base;
        bit to;
        logic [7:0] g, w;
`ifdef TRACE_DUMP_SKIP_EMPTY_EN
        base = 2;
`else
        base = 11;
`endif
        load_basic();
        rx_q.delete(); exp_q.delete();
        push_dump();
        run_dump(0, 1'b0, 0, ff, fc, dc, cb, to);
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout got=timeout want=done"); end
        mm = 0;
        for (int k = 0; k < 9; k++)
            if (rx_q.size() <= base + k || rx_q[base+k] !== lit[k]) mm++;
        checks++;
        if (mm != 0) begin errors++; $display("FAIL basic_entry1_bytes bad_bytes=%0d want 0", mm); end
        mm = drain_compare(fa, g, w);
        checks++;
        if (mm != 0) begin
            errors++;
            $display("FAIL basic_stream mismatches=%0d at=%0d got=%h want=%h", mm, fa, g, w);
        end
`ifndef TRACE_DUMP_SKIP_EMPTY_EN
        checks++;
        if (ff != 2 + CAPACITY*13 + 1 + 1) begin
            errors++;
            $display("FAIL basic_flush_start got=%0d want=%0d", ff, 2 + CAPACITY*13 + 2);
        end
`endif
        checks++;
        if (fc != 1) begin errors++; $display("FAIL basic_flush_cycles got=%0d want=1", fc); end
        checks++;
        if (dc != 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_done done_pulses=%0d busy=%b want 1/0", dc, busy_o);
        end
    endtask

    task automatic test_backpressure();
        int ff, fc, dc, cb, mm, fa;
        bit to;
        logic [7:0] g, w;
        load_basic();
        rx_q.delete(); exp_q.delete(); stab_err = 0;
        push_dump();
        run_dump(0, 1'b1, 0, ff, fc, dc, cb, to);
        checks++;
        if (to) begin errors++; $display("FAIL bp_timeout got=timeout want=done"); end
        mm = drain_compare(fa, g, w);
        checks++;
        if (mm != 0) begin
            errors++;
            $display("FAIL bp_stream mismatches=%0d at=%0d got=%h want=%h", mm, fa, g, w);
        end
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL bp_hold_stable violations=%0d want 0", stab_err); end
        checks++;
        if (dc != 1) begin errors++; $display("FAIL bp_done got=%0d want=1", dc); end
    endtask

    task automatic test_busy_gating();
        int ff, fc, dc, cb, mm, fa;
        bit to;
        logic [7:0] g, w;
        load_random();
        rx_q.delete(); exp_q.delete();
        push_dump();
        trace_en_i = 1'b1;
        run_dump(0, 1'b0, 20, ff, fc, dc, cb, to);
        checks++;
        if (to) begin errors++; $display("FAIL busy_timeout got=timeout want=done"); end
        mm = drain_compare(fa, g, w);
        checks++;
        if (mm != 0) begin
            errors++;
            $display("FAIL busy_single_dump mismatches=%0d at=%0d got=%h want=%h", mm, fa, g, w);
        end
        checks++;
        if (cb != 0) begin errors++; $display("FAIL busy_ctrl_gated bad_cycles=%0d want 0", cb); end
        checks++;
        if (dc != 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_done done_pulses=%0d busy=%b want 1/0", dc, busy_o);
        end
        @(negedge clk);
        checks++;
        if (trace_ctrl_o !== (4'b0001 << TRACE_EN_BIT)) begin
            errors++;
            $display("FAIL busy_enable_restored got=%h want=%h", trace_ctrl_o, 4'b0001 << TRACE_EN_BIT);
        end
        @(posedge clk); #1 trace_en_i = 1'b0;
    endtask

    task automatic test_flush_wait();
        int ff, fc, dc, cb, mm, fa;
        bit to;
        logic [7:0] g, w;
        load_random();
        rx_q.delete(); exp_q.delete();
        push_dump();
        run_dump(10, 1'b0, 0, ff, fc, dc, cb, to);
        checks++;
        if (to) begin errors++; $display("FAIL flush_timeout got=timeout want=done"); end
        checks++;
        if (fc != 11) begin errors++; $display("FAIL flush_hold_cycles got=%0d want=11", fc); end
        checks++;
        if (dc != 1) begin errors++; $display("FAIL flush_done got=%0d want=1", dc); end
        mm = drain_compare(fa, g, w);
        checks++;
        if (mm != 0) begin
            errors++;
            $display("FAIL flush_stream mismatches=%0d at=%0d got=%h want=%h", mm, fa, g, w);
        end
    endtask

    task automatic test_reset_mid();
        int ff, fc, dc, cb, mm, fa, n;
        bit to;
        logic [7:0] g, w;
        load_basic();
        rx_q.delete(); exp_q.delete();
        @(posedge clk); #1 dump_req_i = 1'b1;
        @(posedge clk); #1 dump_req_i = 1'b0;
        n = 0;
        while (rx_q.size() < 6 && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL rstmid_wait got=%0d bytes want=6", rx_q.size()); end
        rst = 1'b1;
        #1;
        checks++;
        if ({trace_ctrl_o, tx_valid_o, tx_data_o, busy_o, done_o, mif.req} !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_outputs ctrl=%h valid=%b data=%h busy=%b done=%b want all 0",
                     trace_ctrl_o, tx_valid_o, tx_data_o, busy_o, done_o);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || trace_ctrl_o !== 4'h0 || tx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle busy=%b ctrl=%h valid=%b want 0/0/0", busy_o, trace_ctrl_o, tx_valid_o);
        end
        rx_q.delete(); exp_q.delete();
        push_dump();
        run_dump(0, 1'b0, 0, ff, fc, dc, cb, to);
        checks++;
        if (to || rx_q.size() == 0 || rx_q[0] !== 8'h5A) begin
            errors++;
            $display("FAIL rstmid_restart first=%h want=5a", (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
        mm = drain_compare(fa, g, w);
        checks++;
        if (mm != 0) begin
            errors++;
            $display("FAIL rstmid_stream mismatches=%0d at=%0d got=%h want=%h", mm, fa, g, w);
        end
    endtask

    task automatic test_port_static();
        checks++;
        if (if_err != 0) begin errors++; $display("FAIL port_we_wdata nonzero_cycles=%0d want 0", if_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_busy_gating();
        test_flush_wait();
        test_reset_mid();
        test_port_static();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
